regfile_mp: RTL and testbench

- Parametrised multi-port integer register file; next generation of the core's 2R/1W regfile.
- Adds configurable read and write port counts, a rising-edge synchronous write, and optional same-cycle write-to-read bypass.
- Adds a pending-write scoreboard (reserve at issue, clear at writeback) so decode can stall on RAW hazards.
- Sits between decode (reads, reserves) and writeback (writes).

---
 rtl/regfile_mp.sv | 102 ++++++++++
 tb/tb_regfile_mp.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// pending-write scoreboard (reserve at issue, clear at writeback).
module regfile_mp #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]  wr_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic [CW-1:0]            pend_cnt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_nxt;
  logic [CW-1:0]    pend_cnt_nxt;

  logic [AW-1:0]    wa     [NUM_WR];
  logic [WIDTH-1:0] wd     [NUM_WR];
  logic [NUM_WR-1:0] wr_ok;
  logic [AW-1:0]    ra     [NUM_RD];
  logic [WIDTH-1:0] rd_val [NUM_RD];
  logic [NUM_RD-1:0] rd_hit;

  // wr_ok excludes writes to the hardwired zero register
  always_comb begin
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      wa[j]    = wr_addr[j*AW +: AW];
      wd[j]    = wr_data[j*WIDTH +: WIDTH];
      wr_ok[j] = wr_en[j] && !(ZERO_REG && (wa[j] == '0));
    end
  end

  // Ascending port scan so the highest-indexed matching writer is forwarded
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_hit  = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra[i]     = rd_addr[i*AW +: AW];
      rd_val[i] = mem[ra[i]];
      if (BYPASS) begin
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (wr_ok[j] && (wa[j] == ra[i])) begin
            rd_val[i] = wd[j];
            rd_hit[i] = 1'b1;
          end
        end
      end
      if (ZERO_REG && (ra[i] == '0))
        rd_val[i] = '0;
      rd_data[i*WIDTH +: WIDTH] = rd_val[i];
      rd_busy[i] = pending[ra[i]] & ~rd_hit[i];
    end
  end

  // Writebacks clear first, then a reservation sets: a new producer wins
  always_comb begin
    pending_nxt = pending;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (wr_en[j])
        pending_nxt[wa[j]] = 1'b0;
    end
    if (rsv_en)
      pending_nxt[rsv_addr] = 1'b1;
    if (ZERO_REG)
      pending_nxt[0] = 1'b0;
    pend_cnt_nxt = '0;
    for (int unsigned k = 0; k < DEPTH; k++)
      pend_cnt_nxt = pend_cnt_nxt + CW'(pending_nxt[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++)
        mem[k] <= '0;
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j])
          mem[wa[j]] <= wd[j];
      end
      pending  <= pending_nxt;
      pend_cnt <= pend_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: a bypassing and a non-bypassing regfile share stimulus;
// expectations come from an associative-array model of the register file.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [5:0]  pend_cnt_b, pend_cnt_n;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          chk_rd;
    logic [31:0] d_b [2];
    logic [31:0] d_n [2];
    logic        b_b [2];
    logic        b_n [2];
    logic [5:0]  cnt;
  } exp_t;

  exp_t exp_q [$];

  int unsigned m_mem  [int];
  bit          m_pend [int];

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2),
               .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(pend_cnt_b));

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2),
               .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_n (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(pend_cnt_n));

  always #5 clk = ~clk;

  function automatic int w_addr(int j);
    logic [4:0] a;
    a = wr_addr[j*5 +: 5];
    return int'(a);
  endfunction

  // Value a reader sees: zero reg, else newest same-cycle writer, else stored
  function automatic logic [31:0] m_read(int a, bit byp);
    if (a == 0) return 32'h0;
    if (byp)
      for (int j = 1; j >= 0; j--)
        if (wr_en[j] && w_addr(j) == a) return wr_data[j*32 +: 32];
    return m_mem.exists(a) ? m_mem[a] : 32'h0;
  endfunction

  function automatic logic m_busy(int a, bit byp);
    if (byp)
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && w_addr(j) == a) return 1'b0;
    return m_pend.exists(a);
  endfunction

  task automatic m_edge();
    if (rst) begin
      m_mem.delete();
      m_pend.delete();
    end else begin
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && w_addr(j) != 0) m_mem[w_addr(j)] = wr_data[j*32 +: 32];
      for (int j = 0; j < 2; j++)
        if (wr_en[j]) m_pend.delete(w_addr(j));
      if (rsv_en && rsv_addr != 0) m_pend[int'(rsv_addr)] = 1'b1;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, queue the expected response, advance the model
  task automatic cycle(input logic r, input logic [1:0] we,
                       input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic re, input logic [4:0] ra,
                       input logic [4:0] a0, input logic [4:0] a1);
    exp_t e;
    rst      = r;
    wr_en    = we;
    wr_addr  = {wa1, wa0};
    wr_data  = {wd1, wd0};
    rsv_en   = re;
    rsv_addr = ra;
    rd_addr  = {a1, a0};
    e.chk_rd = !r;
    for (int i = 0; i < 2; i++) begin
      e.d_b[i] = m_read(int'(rd_addr[i*5 +: 5]), 1'b1);
      e.d_n[i] = m_read(int'(rd_addr[i*5 +: 5]), 1'b0);
      e.b_b[i] = m_busy(int'(rd_addr[i*5 +: 5]), 1'b1);
      e.b_n[i] = m_busy(int'(rd_addr[i*5 +: 5]), 1'b0);
    end
    e.cnt = 6'(m_pend.num());
    exp_q.push_back(e);
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    cycle(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, a0, a1);
  endtask

  task automatic rsv(input logic [4:0] a);
    cycle(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, a, a, a);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pend_cnt_byp", 32'(pend_cnt_b), 32'(e.cnt));
        chk("pend_cnt_nobyp", 32'(pend_cnt_n), 32'(e.cnt));
        if (e.chk_rd) begin
          for (int i = 0; i < 2; i++) begin
            chk($sformatf("rd_data_byp[%0d]", i), rd_data_b[i*32 +: 32], e.d_b[i]);
            chk($sformatf("rd_data_nobyp[%0d]", i), rd_data_n[i*32 +: 32], e.d_n[i]);
            chk($sformatf("rd_busy_byp[%0d]", i), 32'(rd_busy_b[i]), 32'(e.b_b[i]));
            chk($sformatf("rd_busy_nobyp[%0d]", i), 32'(rd_busy_n[i]), 32'(e.b_n[i]));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
    @(posedge clk); #1;
    cycle(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);

    // reset / zero register
    cycle(1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    rd(5'd5, 5'd5);
    cycle(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    rd(5'd5, 5'd5);
    cycle(1'b0, 2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    rd(5'd0, 5'd0);

    // bypass (and its absence on the second instance)
    cycle(1'b0, 2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    rd(5'd7, 5'd7);

    // write collision: port 1 wins
    cycle(1'b0, 2'b11, 5'd3, 32'h11, 5'd3, 32'h22, 1'b0, 5'd0, 5'd3, 5'd3);
    rd(5'd3, 5'd7);

    // scoreboard basic
    rsv(5'd10);
    rd(5'd10, 5'd3);
    cycle(1'b0, 2'b01, 5'd10, 32'h55, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd10);
    rd(5'd10, 5'd10);

    // reserve/write race and reserving x0
    rsv(5'd12);
    rd(5'd12, 5'd12);
    cycle(1'b0, 2'b10, 5'd0, 32'h0, 5'd12, 32'h77, 1'b1, 5'd12, 5'd12, 5'd12);
    rd(5'd12, 5'd12);
    rsv(5'd0);
    rd(5'd0, 5'd12);

    // fill the scoreboard, re-reserve, then reset
    for (int i = 1; i < 32; i++) rsv(5'(i));
    rd(5'd1, 5'd31);
    rsv(5'd1);
    rd(5'd1, 5'd31);
    cycle(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd1);
    rd(5'd1, 5'd31);

    // randomized traffic over a narrow address range to provoke collisions
    for (int n = 0; n < 600; n++) begin
      logic        r, re;
      logic [1:0]  we;
      logic [4:0]  wa0, wa1, ra, a0, a1;
      r   = ($urandom_range(0, 60) == 0);
      we  = 2'($urandom_range(0, 3));
      wa0 = 5'($urandom_range(0, 7));
      wa1 = 5'($urandom_range(0, 7));
      re  = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      a0  = 5'($urandom_range(0, 7));
      a1  = ($urandom_range(0, 1) == 1) ? wa1 : 5'($urandom_range(0, 31));
      cycle(r, we, wa0, 32'($urandom()), wa1, 32'($urandom()), re, ra, a0, a1);
    end
    rd(5'd0, 5'd1);

    @(posedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
